// File: rtl/tm_msg_gen.sv
// -----------------------------------------------------------------------------
// tm_msg_gen
// Message generator that feeds the byte coder over the q / q_rdy / cd_busy
// handshake. Each frame is sent in this order:
//   1. MARKER
//   2. FLAG
//   3. PAYLOAD_LEN payload bytes, lowest byte first, latched when start is accepted
//   4. with TM_MSG_CHKSUM_EN defined, a checksum byte: the sum mod 2^DATA_W of
//      all preceding bytes of the frame
//
// Build macro:
//   TM_MSG_CHKSUM_EN - append the checksum byte. When undefined, neither the
//                      checksum byte nor its accumulator exists.
//
// Ports:
//   clk      in   1                   clock, all logic on posedge
//   n_rst    in   1                   asynchronous active-low reset
//   start    in   1                   frame request, sampled only while idle
//   payload  in   PAYLOAD_LEN*DATA_W  payload bytes, [DATA_W-1:0] sent first
//   cd_busy  in   1                   coder busy (synchronous to clk)
//   q        out  DATA_W              current frame byte
//   q_rdy    out  1                   q valid, waiting for the coder
//   busy     out  1                   frame in progress
//   msg_end  out  1                   one-cycle pulse after last byte consumed
//   byte_idx out  4                   index of the byte on q (0 = MARKER)
// -----------------------------------------------------------------------------
module tm_msg_gen #(
    parameter int                DATA_W      = 8,
    parameter int                PAYLOAD_LEN = 2,
    parameter logic [DATA_W-1:0] MARKER      = DATA_W'(8'h7E),
    parameter logic [DATA_W-1:0] FLAG        = DATA_W'(8'h01)
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    input  logic [PAYLOAD_LEN*DATA_W-1:0] payload,
    input  logic                          cd_busy,
    output logic [DATA_W-1:0]             q,
    output logic                          q_rdy,
    output logic                          busy,
    output logic                          msg_end,
    output logic [3:0]                    byte_idx
);

`ifdef TM_MSG_CHKSUM_EN
    localparam int N = 3 + PAYLOAD_LEN;
`else
    localparam int N = 2 + PAYLOAD_LEN;
`endif
    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;

    state_t                          state_q, state_d;
    logic [DATA_W-1:0]               q_q, q_d;
    logic                            q_rdy_q, q_rdy_d;
    logic                            msg_end_q, msg_end_d;
    logic [3:0]                      byte_idx_q, byte_idx_d;
    logic [PAYLOAD_LEN*DATA_W-1:0]   payload_q, payload_d;
    logic                            cd_busy_dly_q, cd_busy_dly_d;
`ifdef TM_MSG_CHKSUM_EN
    logic [DATA_W-1:0]               chk_q, chk_d;
`endif

    logic              rise, fall;
    logic [3:0]        idx_inc;
    logic [DATA_W-1:0] next_byte;
    logic [DATA_W-1:0] pay_bytes [PAYLOAD_LEN];

    genvar gi;
    generate
        for (gi = 0; gi < PAYLOAD_LEN; gi++) begin : g_unpack
            assign pay_bytes[gi] = payload_q[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Edge detect on the coder busy line. A pulse shorter than one clock is
    // invisible here by design.
    assign cd_busy_dly_d = cd_busy;
    assign rise          = cd_busy & ~cd_busy_dly_q;
    assign fall          = ~cd_busy & cd_busy_dly_q;
    assign idx_inc       = byte_idx_q + 4'd1;

    // Byte that follows the one currently on q. Index 0 (MARKER) is loaded
    // directly from IDLE, so it never appears here.
    always_comb begin
        next_byte = FLAG;
        for (int i = 0; i < PAYLOAD_LEN; i++) begin
            if (idx_inc == 4'(i + 2)) begin
                next_byte = pay_bytes[i];
            end
        end
`ifdef TM_MSG_CHKSUM_EN
        if (idx_inc == LAST_IDX) begin
            next_byte = chk_q;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        q_rdy_d    = q_rdy_q;
        msg_end_d  = 1'b0;
        byte_idx_d = byte_idx_q;
        payload_d  = payload_q;
`ifdef TM_MSG_CHKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            IDLE: begin
                q_d        = '0;
                q_rdy_d    = 1'b0;
                byte_idx_d = 4'd0;
`ifdef TM_MSG_CHKSUM_EN
                chk_d      = '0;
`endif
                if (start) begin
                    payload_d = payload;
                    q_d       = MARKER;
                    q_rdy_d   = 1'b1;
                    state_d   = SEND;
`ifdef TM_MSG_CHKSUM_EN
                    // The accumulator picks up each byte as it is put on q.
                    chk_d     = MARKER;
`endif
                end
            end
            SEND: begin
                // Only a fresh rising edge counts as consumption; a coder that
                // was already busy on entry must drop and raise again.
                if (rise) begin
                    q_rdy_d = 1'b0;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (fall) begin
                    if (byte_idx_q < LAST_IDX) begin
                        byte_idx_d = idx_inc;
                        q_d        = next_byte;
                        q_rdy_d    = 1'b1;
                        state_d    = SEND;
`ifdef TM_MSG_CHKSUM_EN
                        if (idx_inc != LAST_IDX) begin
                            chk_d = chk_q + next_byte;
                        end
`endif
                    end else begin
                        byte_idx_d = 4'd0;
                        q_d        = '0;
                        q_rdy_d    = 1'b0;
                        msg_end_d  = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            q_q           <= '0;
            q_rdy_q       <= 1'b0;
            msg_end_q     <= 1'b0;
            byte_idx_q    <= 4'd0;
            payload_q     <= '0;
            cd_busy_dly_q <= 1'b0;
`ifdef TM_MSG_CHKSUM_EN
            chk_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            q_q           <= q_d;
            q_rdy_q       <= q_rdy_d;
            msg_end_q     <= msg_end_d;
            byte_idx_q    <= byte_idx_d;
            payload_q     <= payload_d;
            cd_busy_dly_q <= cd_busy_dly_d;
`ifdef TM_MSG_CHKSUM_EN
            chk_q         <= chk_d;
`endif
        end
    end

    assign q        = q_q;
    assign q_rdy    = q_rdy_q;
    assign busy     = (state_q != IDLE);
    assign msg_end  = msg_end_q;
    assign byte_idx = byte_idx_q;

endmodule

// File: tb/tb_tm_msg_gen.sv
// -----------------------------------------------------------------------------
// tb_tm_msg_gen
// Bench for tm_msg_gen. Two instances share clk and n_rst:
//   - dut_a: default 2-byte payload
//   - dut_b: long payload
// A select bit routes the stimulus to one instance and muxes its outputs back.
// Expected frames come from a hand-written table and from a byte-list model
// built from the payload value.
// -----------------------------------------------------------------------------
module tb_tm_msg_gen;

`ifdef TM_MSG_CHKSUM_EN
    localparam int LEN_B = 13;
`else
    localparam int LEN_B = 14;
`endif
    localparam logic [7:0] MARKER = 8'h7E;
    localparam logic [7:0] FLAG   = 8'h01;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic               start_x   = 1'b0;
    logic               cd_busy_x = 1'b0;
    logic               sel       = 1'b0;
    logic [LEN_B*8-1:0] payload_x = '0;

    logic       start_a, start_b, cd_busy_a, cd_busy_b;
    logic [7:0] q_a, q_b, q_x;
    logic       q_rdy_a, q_rdy_b, q_rdy_x;
    logic       busy_a, busy_b, busy_x;
    logic       msg_end_a, msg_end_b, msg_end_x;
    logic [3:0] byte_idx_a, byte_idx_b, byte_idx_x;

    assign start_a    = start_x & ~sel;
    assign start_b    = start_x & sel;
    assign cd_busy_a  = cd_busy_x & ~sel;
    assign cd_busy_b  = cd_busy_x & sel;
    assign q_x        = sel ? q_b        : q_a;
    assign q_rdy_x    = sel ? q_rdy_b    : q_rdy_a;
    assign busy_x     = sel ? busy_b     : busy_a;
    assign msg_end_x  = sel ? msg_end_b  : msg_end_a;
    assign byte_idx_x = sel ? byte_idx_b : byte_idx_a;

    tm_msg_gen dut_a (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start_a),
        .payload  (payload_x[15:0]),
        .cd_busy  (cd_busy_a),
        .q        (q_a),
        .q_rdy    (q_rdy_a),
        .busy     (busy_a),
        .msg_end  (msg_end_a),
        .byte_idx (byte_idx_a)
    );

    tm_msg_gen #(.PAYLOAD_LEN(LEN_B)) dut_b (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start_b),
        .payload  (payload_x),
        .cd_busy  (cd_busy_b),
        .q        (q_b),
        .q_rdy    (q_rdy_b),
        .busy     (busy_b),
        .msg_end  (msg_end_b),
        .byte_idx (byte_idx_b)
    );

    int total = 0;
    int bad = 0;
    int end_cnt = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [15:0] pl;
        logic [7:0]  b0, b1, b2, b3, ck;
    } vec_t;
    vec_t tbl [5];

    // Count msg_end pulses: a pulse lasting two cycles counts twice.
    initial begin
        forever begin
            @(posedge clk);
            if (msg_end_x) end_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference frame: MARKER, FLAG, payload bytes low first, optional sum.
    task automatic build_exp(input int len);
        logic [7:0] sum;
        exp_q.delete();
        exp_q.push_back(MARKER);
        exp_q.push_back(FLAG);
        sum = MARKER + FLAG;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(payload_x[i*8 +: 8]);
            sum = sum + payload_x[i*8 +: 8];
        end
`ifdef TM_MSG_CHKSUM_EN
        exp_q.push_back(sum);
`endif
    endtask

    task automatic rand_payload();
        for (int i = 0; i < LEN_B; i++) payload_x[i*8 +: 8] = 8'($urandom);
    endtask

    // Acts as the coder for one frame and checks every byte against exp_q.
    //   pre_busy   : cd_busy already high when start is given
    //   hold_start : start kept high through the frame (back-to-back case)
    //   no_start   : frame was already started by a held start
    //   abort_at   : return while in ACK of this byte index (-1: never)
    task automatic run_frame(input bit pre_busy, input bit hold_start,
                             input bit no_start, input int abort_at);
        int ends0;
        int t;
        int w;
        int h;
        int last;
        ends0 = end_cnt;
        last  = exp_q.size() - 1;
        if (no_start) begin
            start_x = 1'b0;
        end else begin
            @(negedge clk);
            if (pre_busy) cd_busy_x = 1'b1;
            start_x = 1'b1;
            @(negedge clk);
            if (!hold_start) begin
                start_x = 1'b0;
                rand_payload();    // must not affect the latched frame
            end
        end
        if (pre_busy) begin
            repeat (3) @(negedge clk);
            chk("prebusy_wait", {29'd0, q_rdy_x, busy_x, byte_idx_x == 4'd0},
                {29'd0, 1'b1, 1'b1, 1'b1});
            chk("prebusy_q", {24'd0, q_x}, {24'd0, MARKER});
            cd_busy_x = 1'b0;
            @(negedge clk);
            chk("prebusy_fall_no_consume", {28'd0, q_rdy_x, byte_idx_x[2:0]}, 32'h8);
        end
        for (int k = 0; k <= last; k++) begin
            t = 0;
            while (!q_rdy_x && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (!q_rdy_x) begin
                chk("q_rdy_timeout", 32'd0, 32'd1);
                return;
            end
            chk("byte", {20'd0, byte_idx_x, q_x}, {20'd0, 4'(k), exp_q[k]});
            w = $urandom_range(0, 2);
            repeat (w) @(negedge clk);
            cd_busy_x = 1'b1;
            if (!hold_start && $urandom_range(0, 1) == 1) start_x = 1'b1;
            @(negedge clk);
            start_x = hold_start;
            chk("rdy_drop", {22'd0, q_rdy_x, busy_x, q_x}, {22'd0, 1'b0, 1'b1, exp_q[k]});
            if (k == abort_at) return;
            h = $urandom_range(1, 3);
            repeat (h - 1) @(negedge clk);
            cd_busy_x = 1'b0;
            @(negedge clk);
            if (k == last)
                chk("frame_end", {17'd0, msg_end_x, busy_x, q_rdy_x, byte_idx_x, q_x},
                    {17'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0});
            else
                chk("mid_frame", {30'd0, msg_end_x, busy_x}, {30'd0, 1'b0, 1'b1});
        end
        @(negedge clk);
        if (hold_start) begin
            chk("b2b_restart", {18'd0, busy_x, q_rdy_x, byte_idx_x, q_x},
                {18'd0, 1'b1, 1'b1, 4'd0, MARKER});
            start_x = 1'b0;
        end
        chk("msg_end_count", 32'(end_cnt - ends0), 32'd1);
        $display("frame sel=%0d bytes=%0d ends=%0d", sel, exp_q.size(), end_cnt - ends0);
    endtask

    initial begin
        int ends0;
        // tbl fields: payload, then expected MARKER, FLAG, low byte, high byte, checksum
        tbl[0] = '{pl: 16'hA55A, b0: 8'h7E, b1: 8'h01, b2: 8'h5A, b3: 8'hA5, ck: 8'h7E};
        tbl[1] = '{pl: 16'h0000, b0: 8'h7E, b1: 8'h01, b2: 8'h00, b3: 8'h00, ck: 8'h7F};
        tbl[2] = '{pl: 16'hFFFF, b0: 8'h7E, b1: 8'h01, b2: 8'hFF, b3: 8'hFF, ck: 8'h7D};
        tbl[3] = '{pl: 16'h1234, b0: 8'h7E, b1: 8'h01, b2: 8'h34, b3: 8'h12, ck: 8'hC5};
        tbl[4] = '{pl: 16'h8181, b0: 8'h7E, b1: 8'h01, b2: 8'h81, b3: 8'h81, ck: 8'h81};

        repeat (2) @(negedge clk);
        chk("reset_state", {17'd0, q_x, q_rdy_x, busy_x, msg_end_x, byte_idx_x}, 32'd0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {17'd0, q_x, q_rdy_x, busy_x, msg_end_x, byte_idx_x}, 32'd0);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            payload_x[15:0] = tbl[i].pl;
            exp_q.delete();
            exp_q.push_back(tbl[i].b0);
            exp_q.push_back(tbl[i].b1);
            exp_q.push_back(tbl[i].b2);
            exp_q.push_back(tbl[i].b3);
`ifdef TM_MSG_CHKSUM_EN
            exp_q.push_back(tbl[i].ck);
`endif
            run_frame(1'b0, 1'b0, 1'b0, -1);
        end

        // Reset while in ACK of byte 2
        payload_x[15:0] = 16'hA55A;
        build_exp(2);
        ends0 = end_cnt;
        run_frame(1'b0, 1'b0, 1'b0, 2);
        #2 n_rst = 1'b0;
        #1 chk("abort_reset", {17'd0, q_x, q_rdy_x, busy_x, msg_end_x, byte_idx_x}, 32'd0);
        cd_busy_x = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_msg_end", 32'(end_cnt - ends0), 32'd0);
        payload_x[15:0] = 16'hA55A;
        build_exp(2);
        run_frame(1'b0, 1'b0, 1'b0, -1);

        // start held high across msg_end: second frame follows with no gap
        payload_x[15:0] = 16'h3C96;
        build_exp(2);
        run_frame(1'b0, 1'b1, 1'b0, -1);
        run_frame(1'b0, 1'b0, 1'b1, -1);

        // Coder already busy when start arrives
        payload_x[15:0] = 16'hBEEF;
        build_exp(2);
        run_frame(1'b1, 1'b0, 1'b0, -1);

        // Randomised payloads and coder timing
        for (int i = 0; i < 12; i++) begin
            rand_payload();
            build_exp(2);
            run_frame(1'b0, 1'b0, 1'b0, -1);
        end

        // Long payload instance
        sel = 1'b1;
        @(negedge clk);
        rand_payload();
        build_exp(LEN_B);
        run_frame(1'b0, 1'b0, 1'b0, -1);
        sel = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
